// File: rtl/bios_boot_loader_if.sv
// Bus bundle between the boot loader, the BIOS ROM read port and the main memory write port.
interface bios_boot_loader_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 9,
  parameter int RAM_ADDR_WIDTH = 16
);
  // Write handshake: a word transfers on a clock edge where ram_we && ram_ready; once ram_we
  // is raised, ram_addr/ram_data stay stable until that edge. bios_q follows bios_addr by one cycle.
  logic [ADDR_WIDTH-1:0]     bios_addr;
  logic [DATA_WIDTH-1:0]     bios_q;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]     ram_data;
  logic                      ram_we;
  logic                      ram_ready;

  modport master (output bios_addr, ram_addr, ram_data, ram_we, input bios_q, ram_ready);
  modport slave  (input bios_addr, ram_addr, ram_data, ram_we, output bios_q, ram_ready);
endinterface

// File: rtl/bios_boot_loader.sv
// Boot sequencer: copies COPY_WORDS BIOS ROM words into main memory and holds the CPU until done.
// Optional checksum verification of the image is enabled by defining BIOS_BOOT_CHECKSUM_EN.
module bios_boot_loader #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 9,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int RAM_BASE       = 0,
  parameter int COPY_WORDS     = 512,
  parameter int AUTO_START     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  bios_boot_loader_if.master    bus,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_hold,
`ifdef BIOS_BOOT_CHECKSUM_EN
  output logic                  boot_error,
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  output logic [2:0]            dbg_state_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef BIOS_BOOT_CHECKSUM_EN
  localparam logic [2:0] S_ERROR = 3'd5;
`endif

  localparam logic [ADDR_WIDTH-1:0]     LAST_IDX = ADDR_WIDTH'(COPY_WORDS - 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] BASE     = RAM_ADDR_WIDTH'(RAM_BASE);

  logic [2:0]                state_q, state_d;
  logic [ADDR_WIDTH-1:0]     idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]     bios_addr_q, bios_addr_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]     ram_data_q, ram_data_d;
`ifdef BIOS_BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]     checksum_q, checksum_d;
  logic [DATA_WIDTH-1:0]     sum_next;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bios_addr_d = bios_addr_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
`ifdef BIOS_BOOT_CHECKSUM_EN
    checksum_d  = checksum_q;
    sum_next    = checksum_q + ram_data_q;
`endif
    case (state_q)
      S_IDLE: begin
        // IDLE is only reachable through reset, so AUTO_START fires exactly once after release.
        if (AUTO_START != 0 || start) begin
          state_d     = S_READ;
          idx_d       = '0;
          bios_addr_d = '0;
`ifdef BIOS_BOOT_CHECKSUM_EN
          checksum_d  = '0;
`endif
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        ram_data_d = bus.bios_q;
        ram_addr_d = BASE + RAM_ADDR_WIDTH'(idx_q);
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (bus.ram_ready) begin
`ifdef BIOS_BOOT_CHECKSUM_EN
          checksum_d = sum_next;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef BIOS_BOOT_CHECKSUM_EN
            state_d = (sum_next == '0) ? S_DONE : S_ERROR;
`else
            state_d = S_DONE;
`endif
          end else begin
            idx_d       = idx_q + 1'b1;
            bios_addr_d = idx_q + 1'b1;
            state_d     = S_READ;
          end
        end
      end
`ifdef BIOS_BOOT_CHECKSUM_EN
      S_ERROR,
`endif
      S_DONE: begin
        if (start) begin
          state_d     = S_READ;
          idx_d       = '0;
          bios_addr_d = '0;
`ifdef BIOS_BOOT_CHECKSUM_EN
          checksum_d  = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      bios_addr_q <= '0;
      ram_addr_q  <= BASE;
      ram_data_q  <= '0;
`ifdef BIOS_BOOT_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bios_addr_q <= bios_addr_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
`ifdef BIOS_BOOT_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  assign bus.bios_addr = bios_addr_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_data  = ram_data_q;
  assign bus.ram_we    = (state_q == S_WRITE);
  assign busy          = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_WRITE);
  assign done          = (state_q == S_DONE);
  assign cpu_hold      = (state_q != S_DONE);
  assign dbg_state_o   = state_q;
`ifdef BIOS_BOOT_CHECKSUM_EN
  assign boot_error    = (state_q == S_ERROR);
  assign checksum      = checksum_q;
`endif

endmodule

// File: tb/tb_bios_boot_loader.sv
// Bench for bios_boot_loader: two instances (base 0 auto-start, base FFFE manual start), 4-word image.
`timescale 1ns/1ps
module tb_bios_boot_loader;
  localparam int DW = 16;
  localparam int AW = 9;
  localparam int RW = 16;
  localparam int NW = 4;
`ifdef BIOS_BOOT_CHECKSUM_EN
  localparam logic [DW-1:0] LAST_W = 16'hFFFA;
`else
  localparam logic [DW-1:0] LAST_W = 16'h0004;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic busy_a, done_a, hold_a, busy_b, done_b, hold_b;
  logic [2:0] dbg_a, dbg_b;
`ifdef BIOS_BOOT_CHECKSUM_EN
  logic berr_a, berr_b;
  logic [DW-1:0] csum_a, csum_b;
`endif

  logic [DW-1:0] rom [0:(1<<AW)-1];
  logic [RW+DW-1:0] exp_a[$];
  logic [RW+DW-1:0] exp_b[$];
  int total = 0;
  int bad = 0;

  bios_boot_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RW)) bus_a ();
  bios_boot_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RW)) bus_b ();

  bios_boot_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RW), .RAM_BASE(0),
                     .COPY_WORDS(NW), .AUTO_START(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bus(bus_a.master),
    .busy(busy_a), .done(done_a), .cpu_hold(hold_a),
`ifdef BIOS_BOOT_CHECKSUM_EN
    .boot_error(berr_a), .checksum(csum_a),
`endif
    .dbg_state_o(dbg_a));

  bios_boot_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RW), .RAM_BASE(16'hFFFE),
                     .COPY_WORDS(NW), .AUTO_START(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bus(bus_b.master),
    .busy(busy_b), .done(done_b), .cpu_hold(hold_b),
`ifdef BIOS_BOOT_CHECKSUM_EN
    .boot_error(berr_b), .checksum(csum_b),
`endif
    .dbg_state_o(dbg_b));

  // ---------------- clock / ROM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus_a.bios_q <= rom[bus_a.bios_addr];
    bus_b.bios_q <= rom[bus_b.bios_addr];
  end

  // ---------------- scoreboard step: one negedge, pop on every accepted write ----------------
  task automatic tick();
    logic [RW+DW-1:0] e;
    @(negedge clk);
    if (bus_a.ram_we === 1'b1 && bus_a.ram_ready === 1'b1) begin
      total++;
      if (exp_a.size() == 0) begin
        bad++;
        $display("FAIL wr_a: got addr=%h data=%h, required no write", bus_a.ram_addr, bus_a.ram_data);
      end else begin
        e = exp_a.pop_front();
        if ({bus_a.ram_addr, bus_a.ram_data} !== e) begin
          bad++;
          $display("FAIL wr_a: got addr=%h data=%h, required addr=%h data=%h",
                   bus_a.ram_addr, bus_a.ram_data, e[RW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
    if (bus_b.ram_we === 1'b1 && bus_b.ram_ready === 1'b1) begin
      total++;
      if (exp_b.size() == 0) begin
        bad++;
        $display("FAIL wr_b: got addr=%h data=%h, required no write", bus_b.ram_addr, bus_b.ram_data);
      end else begin
        e = exp_b.pop_front();
        if ({bus_b.ram_addr, bus_b.ram_data} !== e) begin
          bad++;
          $display("FAIL wr_b: got addr=%h data=%h, required addr=%h data=%h",
                   bus_b.ram_addr, bus_b.ram_data, e[RW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  endtask

  task automatic push_a();
    for (int i = 0; i < NW; i++) exp_a.push_back({RW'(i), rom[i]});
  endtask

  // Runs one copy on dut_a; cycles = negedges from first busy to done (or error).
  task automatic run_copy(input bit pulse, input int stall_word, input int stall_len,
                          input bit poke_start, output int cycles, output bit hold_ok);
    int n, t_busy, t_end, stall_cnt;
    bit stalling;
    n = 0; t_busy = -1; t_end = -1; stall_cnt = 0; stalling = 0; hold_ok = 1;
    if (pulse) start_a = 1'b1;
    while (t_end < 0 && n < 200) begin
      tick();
      n++;
      start_a = 1'b0;
      if (busy_a === 1'b1 && t_busy < 0) t_busy = n;
      if (done_a === 1'b1) t_end = n;
`ifdef BIOS_BOOT_CHECKSUM_EN
      if (berr_a === 1'b1) t_end = n;
`endif
      if (t_busy >= 0 && t_end < 0 && hold_a !== 1'b1) hold_ok = 0;
      if (!stalling && stall_cnt == 0 && stall_len > 0 && busy_a === 1'b1 &&
          int'(bus_a.bios_addr) == stall_word && bus_a.ram_we === 1'b0) begin
        bus_a.ram_ready = 1'b0;
        stalling = 1;
      end else if (stalling && bus_a.ram_we === 1'b1) begin
        stall_cnt++;
        total++;
        if ({bus_a.ram_addr, bus_a.ram_data} !== {RW'(stall_word), rom[stall_word]}) begin
          bad++;
          $display("FAIL stall_hold: cycle %0d got addr=%h data=%h, required addr=%h data=%h",
                   stall_cnt, bus_a.ram_addr, bus_a.ram_data, RW'(stall_word), rom[stall_word]);
        end
        if (stall_cnt == stall_len) begin
          @(posedge clk);
          #1 bus_a.ram_ready = 1'b1;
          stalling = 0;
        end
      end
      if (poke_start && busy_a === 1'b1 && (n % 4) == 2) start_a = 1'b1;
    end
    total++;
    if (t_end < 0) begin
      bad++;
      $display("FAIL copy_timeout: got no done within 200 cycles, required done");
      cycles = -1;
    end else begin
      cycles = t_end - t_busy;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus_a.ram_ready = 1'b1;
    bus_b.ram_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({bus_a.bios_addr, bus_a.ram_addr, bus_a.ram_data, bus_a.ram_we, busy_a, done_a, hold_a}
        !== {9'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_a: got ba=%h ra=%h rd=%h we=%b busy=%b done=%b hold=%b, required 0,0,0,0,0,0,1",
               bus_a.bios_addr, bus_a.ram_addr, bus_a.ram_data, bus_a.ram_we, busy_a, done_a, hold_a);
    end
    total++;
    if ({bus_b.bios_addr, bus_b.ram_addr, bus_b.ram_we, busy_b, done_b, hold_b}
        !== {9'd0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_b: got ba=%h ra=%h we=%b busy=%b done=%b hold=%b, required 0,fffe,0,0,0,1",
               bus_b.bios_addr, bus_b.ram_addr, bus_b.ram_we, busy_b, done_b, hold_b);
    end
    total++;
    if (dbg_a !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: got %0d, required 0 (IDLE)", dbg_a);
    end
`ifdef BIOS_BOOT_CHECKSUM_EN
    total++;
    if ({berr_a, csum_a} !== {1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL reset_csum: got err=%b sum=%h, required 0,0000", berr_a, csum_a);
    end
`endif
  endtask

  task automatic test_basic();
    int cyc;
    bit hold_ok;
    push_a();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_copy(1'b0, -1, 0, 1'b0, cyc, hold_ok);
    total++;
    if (cyc !== 3 * NW) begin
      bad++;
      $display("FAIL basic_timing: got %0d cycles, required %0d", cyc, 3 * NW);
    end
    total++;
    if ({done_a, hold_a, busy_a, bus_a.ram_we} !== 4'b1000) begin
      bad++;
      $display("FAIL basic_done: got done=%b hold=%b busy=%b we=%b, required 1,0,0,0",
               done_a, hold_a, busy_a, bus_a.ram_we);
    end
    total++;
    if (hold_ok !== 1'b1) begin
      bad++;
      $display("FAIL basic_hold: got cpu_hold low during copy, required high");
    end
    total++;
    if (exp_a.size() != 0) begin
      bad++;
      $display("FAIL basic_writes: got %0d writes missing, required 0", exp_a.size());
    end
  endtask

  task automatic test_stall();
    int cyc;
    bit hold_ok;
    push_a();
    run_copy(1'b1, 2, 5, 1'b0, cyc, hold_ok);
    total++;
    if (cyc !== 3 * NW + 5) begin
      bad++;
      $display("FAIL stall_timing: got %0d cycles, required %0d", cyc, 3 * NW + 5);
    end
    total++;
    if (hold_ok !== 1'b1 || hold_a !== 1'b0) begin
      bad++;
      $display("FAIL recopy_hold: got hold_ok=%b hold_at_done=%b, required 1,0", hold_ok, hold_a);
    end
    total++;
    if (exp_a.size() != 0) begin
      bad++;
      $display("FAIL stall_writes: got %0d writes missing, required 0", exp_a.size());
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    bit hold_ok;
    push_a();
    run_copy(1'b1, -1, 0, 1'b1, cyc, hold_ok);
    repeat (4) tick();
    total++;
    if (cyc !== 3 * NW) begin
      bad++;
      $display("FAIL busy_start_timing: got %0d cycles, required %0d", cyc, 3 * NW);
    end
    total++;
    if ({done_a, busy_a} !== 2'b10 || exp_a.size() != 0) begin
      bad++;
      $display("FAIL busy_start_done: got done=%b busy=%b missing=%0d, required 1,0,0",
               done_a, busy_a, exp_a.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit hold_ok, hit;
    hit = 0;
    exp_a.push_back({16'h0000, rom[0]});
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      tick();
      if (bus_a.ram_we === 1'b1 && bus_a.ram_addr === 16'h0001) hit = 1;
      else if (busy_a === 1'b1 && bus_a.bios_addr === 9'd1) bus_a.ram_ready = 1'b0;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL mid_reach: got no WRITE of word 1, required one");
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus_a.bios_addr, bus_a.ram_addr, bus_a.ram_data, bus_a.ram_we, busy_a, done_a, hold_a}
        !== {9'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset: got ba=%h ra=%h rd=%h we=%b busy=%b done=%b hold=%b, required 0,0,0,0,0,0,1",
               bus_a.bios_addr, bus_a.ram_addr, bus_a.ram_data, bus_a.ram_we, busy_a, done_a, hold_a);
    end
    total++;
    if (exp_a.size() != 0) begin
      bad++;
      $display("FAIL mid_word0: got %0d writes missing, required 0", exp_a.size());
    end
    repeat (2) tick();
    push_a();
    @(posedge clk);
    #1 begin
      bus_a.ram_ready = 1'b1;
      rst_n = 1'b1;
    end
    run_copy(1'b0, -1, 0, 1'b0, cyc, hold_ok);
    total++;
    if (cyc !== 3 * NW || exp_a.size() != 0) begin
      bad++;
      $display("FAIL mid_restart: got %0d cycles missing=%0d, required %0d,0", cyc, exp_a.size(), 3 * NW);
    end
  endtask

  task automatic test_wrap();
    int n, t_busy, t_done;
    logic [RW-1:0] a;
    n = 0; t_busy = -1; t_done = -1;
    repeat (3) tick();
    total++;
    if ({busy_b, done_b, hold_b, bus_b.ram_we} !== 4'b0010) begin
      bad++;
      $display("FAIL manual_idle: got busy=%b done=%b hold=%b we=%b, required 0,0,1,0",
               busy_b, done_b, hold_b, bus_b.ram_we);
    end
    for (int i = 0; i < NW; i++) begin
      a = 16'hFFFE + RW'(i);
      exp_b.push_back({a, rom[i]});
    end
    start_b = 1'b1;
    while (t_done < 0 && n < 200) begin
      tick();
      n++;
      start_b = 1'b0;
      if (busy_b === 1'b1 && t_busy < 0) t_busy = n;
      if (done_b === 1'b1) t_done = n;
    end
    total++;
    if (t_done < 0 || (t_done - t_busy) != 3 * NW) begin
      bad++;
      $display("FAIL wrap_timing: got busy@%0d done@%0d, required %0d apart", t_busy, t_done, 3 * NW);
    end
    total++;
    if (exp_b.size() != 0 || hold_b !== 1'b0) begin
      bad++;
      $display("FAIL wrap_writes: got missing=%0d hold=%b, required 0,0", exp_b.size(), hold_b);
    end
  endtask

`ifdef BIOS_BOOT_CHECKSUM_EN
  task automatic test_checksum();
    int cyc;
    bit hold_ok;
    push_a();
    run_copy(1'b1, -1, 0, 1'b0, cyc, hold_ok);
    total++;
    if ({done_a, berr_a, hold_a, csum_a} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL csum_good: got done=%b err=%b hold=%b sum=%h, required 1,0,0,0000",
               done_a, berr_a, hold_a, csum_a);
    end
    rom[3] = 16'hFFFB;
    push_a();
    run_copy(1'b1, -1, 0, 1'b0, cyc, hold_ok);
    repeat (2) tick();
    total++;
    if ({done_a, berr_a, hold_a, busy_a, csum_a} !== {1'b0, 1'b1, 1'b1, 1'b0, 16'h0001}) begin
      bad++;
      $display("FAIL csum_bad: got done=%b err=%b hold=%b busy=%b sum=%h, required 0,1,1,0,0001",
               done_a, berr_a, hold_a, busy_a, csum_a);
    end
    rom[3] = LAST_W;
    push_a();
    run_copy(1'b1, -1, 0, 1'b0, cyc, hold_ok);
    total++;
    if ({done_a, berr_a, exp_a.size() == 0} !== 3'b101) begin
      bad++;
      $display("FAIL csum_recover: got done=%b err=%b missing=%0d, required 1,0,0",
               done_a, berr_a, exp_a.size());
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = DW'(16'hA000 + i);
    rom[0] = 16'h0001;
    rom[1] = 16'h0002;
    rom[2] = 16'h0003;
    rom[3] = LAST_W;
    test_reset();
    test_basic();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_wrap();
`ifdef BIOS_BOOT_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
